hazard_stall_ctrl: RTL

- **Role:** central stall, flush and bubble controller for the 5-stage rv32i pipeline. It is the counterpart of the EX/MEM→EX forwarding path: it handles the hazards that forwarding cannot cover.
- **Hazards handled:** load-use, I-cache misses, D-cache misses and taken-branch flushes.
- **Outputs:** per-stage register load enables and bubble injects. It also tracks cache responses that return while the pipeline is frozen for the other cache, so that no memory access is re-issued or lost.
- **Position:** sits beside the datapath. It reads stage control words and drives only pipeline-register control.

---
 rtl/rv32i_types.sv | 30 +++
 rtl/hazard_lu_detect.sv | 26 ++
 rtl/hazard_stall_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types: register numbers, opcodes, stage control
// words and the hazard controller state encoding.
package rv32i_types;

  typedef logic [4:0] rv32i_reg;

  typedef enum logic [6:0] {
    op_load  = 7'b0000011,
    op_imm   = 7'b0010011,
    op_auipc = 7'b0010111,
    op_store = 7'b0100011,
    op_reg   = 7'b0110011,
    op_lui   = 7'b0110111,
    op_br    = 7'b1100011,
    op_jal   = 7'b1101111
  } rv32i_opcode;

  typedef struct packed {
    rv32i_opcode opcode;
    logic        load_regfile;
    logic        mem_read;
    logic        mem_write;
  } rv32i_control_word;

  typedef enum logic {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } hazard_state_t;

endpackage

// File: rtl/hazard_lu_detect.sv
// Load-use detector: a load in EX whose destination feeds a source that the
// ID instruction actually reads.
module hazard_lu_detect
  import rv32i_types::*;
(
  input  rv32i_reg          ID_rs1_num,
  input  rv32i_reg          ID_rs2_num,
  input  rv32i_opcode       ID_opcode,
  input  rv32i_reg          EX_rd_num,
  input  rv32i_control_word EX_ctrlword,
  output logic              lu
);

  logic rs1_used, rs2_used, ex_load;

  // Immediate-only formats carry garbage in the rs fields; ignore them.
  assign rs1_used = !(ID_opcode inside {op_lui, op_auipc, op_jal});
  assign rs2_used =   ID_opcode inside {op_reg, op_store, op_br};

  assign ex_load = (EX_ctrlword.opcode == op_load) && EX_ctrlword.load_regfile &&
                   (EX_rd_num != '0);

  assign lu = ex_load && ((rs1_used && (ID_rs1_num == EX_rd_num)) ||
                          (rs2_used && (ID_rs2_num == EX_rd_num)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush/bubble controller: freezes on cache misses, flushes on
// taken branches, bubbles load-use, and remembers caches that finished early.
module hazard_stall_ctrl
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  rv32i_reg          ID_rs1_num,
  input  rv32i_reg          ID_rs2_num,
  input  rv32i_control_word ID_ctrlword,
  input  rv32i_reg          EX_rd_num,
  input  rv32i_control_word EX_ctrlword,
  input  logic              EX_br_taken,
  input  rv32i_control_word MEM_ctrlword,
  input  logic              icache_resp,
  input  logic              dcache_resp,
  output logic              icache_read,
  output logic              dcache_req_en,
  output logic              icache_capture,
  output logic              dcache_capture,
  output logic              pc_load,
  output logic              IF_ID_load,
  output logic              ID_EX_load,
  output logic              EX_MEM_load,
  output logic              MEM_WB_load,
  output logic              IF_ID_bubble,
  output logic              ID_EX_bubble,
  output logic [31:0]       lu_stall_count,
  output logic [31:0]       mem_stall_count,
  output logic [31:0]       flush_count
);

  hazard_state_t state;
  logic i_done, d_done;
  logic lu, dmem_access, i_pend, d_pend, freeze;
  logic win_br, win_lu;
  logic unused_ctrl;

  hazard_lu_detect u_lu (
    .ID_rs1_num  (ID_rs1_num),
    .ID_rs2_num  (ID_rs2_num),
    .ID_opcode   (ID_ctrlword.opcode),
    .EX_rd_num   (EX_rd_num),
    .EX_ctrlword (EX_ctrlword),
    .lu          (lu)
  );

  assign unused_ctrl = ^{ID_ctrlword.load_regfile, ID_ctrlword.mem_read, ID_ctrlword.mem_write,
                         EX_ctrlword.mem_read, EX_ctrlword.mem_write,
                         MEM_ctrlword.opcode, MEM_ctrlword.load_regfile};

  assign dmem_access = MEM_ctrlword.mem_read | MEM_ctrlword.mem_write;
  assign i_pend      = !icache_resp & !i_done;
  assign d_pend      = dmem_access & !dcache_resp & !d_done;
  // Held low in reset so nothing downstream (flags, counters) sees a freeze.
  assign freeze      = !rst & (i_pend | d_pend);
  assign win_br      = !rst & !freeze & EX_br_taken;
  assign win_lu      = !rst & !freeze & !EX_br_taken & lu;

  always_comb begin
    icache_read    = 1'b0;
    dcache_req_en  = 1'b0;
    icache_capture = 1'b0;
    dcache_capture = 1'b0;
    pc_load        = 1'b0;
    IF_ID_load     = 1'b0;
    ID_EX_load     = 1'b0;
    EX_MEM_load    = 1'b0;
    MEM_WB_load    = 1'b0;
    IF_ID_bubble   = 1'b0;
    ID_EX_bubble   = 1'b0;
    if (!rst) begin
      icache_read    = !i_done;
      dcache_req_en  = dmem_access & !d_done;
      icache_capture = freeze & icache_resp;
      dcache_capture = freeze & dmem_access & dcache_resp;
      if (!freeze) begin
        pc_load      = !win_lu;
        IF_ID_load   = !win_lu;
        ID_EX_load   = 1'b1;
        EX_MEM_load  = 1'b1;
        MEM_WB_load  = 1'b1;
        IF_ID_bubble = win_br;
        ID_EX_bubble = win_br | win_lu;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RUN;
      i_done          <= 1'b0;
      d_done          <= 1'b0;
      lu_stall_count  <= '0;
      mem_stall_count <= '0;
      flush_count     <= '0;
    end else begin
      state <= freeze ? FROZEN : RUN;
      // Flags can only be set during a freeze, so the first RUN cycle after
      // FROZEN is exactly when the stages consume the side-registered data.
      if (state == FROZEN && !freeze) begin
        i_done <= 1'b0;
        d_done <= 1'b0;
      end else begin
        if (icache_capture) i_done <= 1'b1;
        if (dcache_capture) d_done <= 1'b1;
      end
      if (freeze) mem_stall_count <= mem_stall_count + 32'd1;
      if (win_lu) lu_stall_count  <= lu_stall_count + 32'd1;
      if (win_br) flush_count     <= flush_count + 32'd1;
    end
  end

endmodule
